// File: rtl/id_ex_stage_pkg.sv
// Purpose : shared constants for the ID/EX stage and the units that read its
//           control bundle (execute, memory, forwarding).
// Contents: control-bundle width and bit positions, hard-zero register index.
package id_ex_stage_pkg;

    // Packed execute/memory/writeback control bundle.
    localparam int CTRL_W         = 8;
    localparam int CTRL_MEMWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_ALUOP_LSB = 3;
    localparam int CTRL_ALUOP_W   = 3;

    // Register 0 always reads as zero, so it can never carry a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : id_ex_stage_pkg

// File: rtl/id_ex_stage_load_use_detect.sv
// Purpose : combinational load-use hazard compare between the instruction in
//           EX and the instruction in decode. Shared with the forwarding unit.
// Ports   : ex_valid/ex_mem_read/ex_wreg  - instruction currently in EX
//           id_valid/id_rs/id_rt/id_rs_used/id_rt_used - instruction in decode
//           luh                          - decode needs a value a load in EX
//                                          has not produced yet
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    output logic              luh
);

    logic load_in_ex;
    logic rs_dep;
    logic rt_dep;

    always_comb begin
        // A load targeting register 0 writes nothing visible, so it cannot stall.
        load_in_ex = ex_valid & ex_mem_read & (ex_wreg != REG_AW'(REG_ZERO));
        rs_dep     = id_rs_used & (id_rs == ex_wreg);
        rt_dep     = id_rt_used & (id_rt == ex_wreg);
        luh        = load_in_ex & id_valid & (rs_dep | rt_dep);
    end

endmodule : load_use_detect

// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register. Captures decoded operands and controls,
//           inserts bubbles on load-use hazards and EX redirects, holds on EX
//           back-pressure, and counts hazard/flush events (saturating).
// Ports   : clk, reset (sync, active-low)
//           id_*        - decoded instruction from the decode stage
//           ex_stall    - EX cannot advance; hold everything
//           ex_redirect - taken branch/jump in EX; flush the decode slot
//           ex_*        - registered copy of id_* (or a bubble)
//           id_stall    - hold PC and IF/ID this cycle
//           hazard_cnt, flush_cnt - saturating event counters
//
// Flow control: this stage has no valid/ready pair. ex_stall is the EX-side
// "not ready": while it is high nothing in this stage changes. id_stall is our
// "not ready" to decode: while it is high decode must re-present the same
// instruction next cycle. A bubble is an all-zero EX slot (ex_valid=0).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_stall,
    input  logic              ex_redirect,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              id_stall,
    output logic [CNT_W-1:0]  hazard_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Whole EX slot kept as one vector so a bubble is simply '0.
    localparam int BUNDLE_W = 1 + 4 * DATA_W + 3 * REG_AW + CTRL_W + 2;

    logic [BUNDLE_W-1:0] ex_bundle_d, ex_bundle_q;
    logic [BUNDLE_W-1:0] id_bundle;
    logic [CNT_W-1:0]    hazard_cnt_d, hazard_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_d, flush_cnt_q;
    logic                luh;

    assign id_bundle = {id_valid, id_pc, id_rs, id_rt, id_wreg, id_rdata1,
                        id_rdata2, id_imm, id_ctrl, id_reg_write, id_mem_read};

    assign {ex_valid, ex_pc, ex_rs, ex_rt, ex_wreg, ex_rdata1,
            ex_rdata2, ex_imm, ex_ctrl, ex_reg_write, ex_mem_read} = ex_bundle_q;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_luh (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_wreg     (ex_wreg),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .luh         (luh)
    );

    always_comb begin
        ex_bundle_d  = ex_bundle_q;
        hazard_cnt_d = hazard_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (ex_stall) begin
            // Hold. A pending redirect is re-asserted by EX once it advances.
        end else if (ex_redirect) begin
            ex_bundle_d = '0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (luh) begin
            ex_bundle_d = '0;
            if (hazard_cnt_q != '1) hazard_cnt_d = hazard_cnt_q + 1'b1;
        end else if (id_valid) begin
            ex_bundle_d = id_bundle;
        end else begin
            ex_bundle_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_bundle_q  <= '0;
            hazard_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_bundle_q  <= ex_bundle_d;
            hazard_cnt_q <= hazard_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // A redirect kills the dependent instruction anyway, so no need to stall it.
    assign id_stall   = reset & (ex_stall | (luh & ~ex_redirect));
    assign hazard_cnt = hazard_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule : id_ex_stage
